// File: rtl/sd_wb_master_arb_pkg.sv
// Shared types and constants for the SD DMA Wishbone master arbiter.
// Holds the arbiter state encoding, owner encoding and default watchdog limit.
package sd_wb_master_arb_pkg;

    typedef enum logic {
        SD_ARB_IDLE = 1'b0,
        SD_ARB_BUSY = 1'b1
    } sd_arb_state_e;

    typedef enum logic {
        SD_ARB_OWNER_RX = 1'b0,
        SD_ARB_OWNER_TX = 1'b1
    } sd_arb_owner_e;

    localparam int SD_ARB_TIMEOUT_DEF = 255;
    localparam int SD_ARB_WD_W        = 8;

endpackage

// File: rtl/sd_wb_watchdog.sv
// Per-transfer watchdog: 8-bit counter held at zero by clr_i, counting while
// en_i is high. Ports: clk, rst, clr_i, en_i, tc_o (count == TIMEOUT).
import sd_wb_master_arb_pkg::*;

module sd_wb_watchdog #(
    parameter int TIMEOUT = SD_ARB_TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam logic [SD_ARB_WD_W-1:0] TC = SD_ARB_WD_W'(TIMEOUT);
    localparam logic [SD_ARB_WD_W-1:0] MAX = '1;

    logic [SD_ARB_WD_W-1:0] count_q;
    logic [SD_ARB_WD_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && count_q != MAX) begin
            // saturate so a stuck enable can never wrap past TIMEOUT
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc_o = (count_q == TC);

endmodule

// File: rtl/sd_wb_master_arb.sv
// Round-robin arbiter sharing one Wishbone master between the RX and TX
// fillers. Ports: rx_*/tx_* requester sides, m_wb_* master port,
// busy_o (transfer granted), timeout_o (sticky watchdog abort flag).
import sd_wb_master_arb_pkg::*;

module sd_wb_master_arb #(
    parameter int TIMEOUT = SD_ARB_TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_cyc_i,
    input  logic        rx_stb_i,
    input  logic        rx_we_i,
    input  logic [31:0] rx_adr_i,
    input  logic [31:0] rx_dat_i,
    output logic        rx_ack_o,
    output logic        rx_err_o,
    input  logic        tx_cyc_i,
    input  logic        tx_stb_i,
    input  logic        tx_we_i,
    input  logic [31:0] tx_adr_i,
    input  logic [31:0] tx_dat_i,
    output logic [31:0] tx_dat_o,
    output logic        tx_ack_o,
    output logic        tx_err_o,
    output logic [31:0] m_wb_adr_o,
    output logic [31:0] m_wb_dat_o,
    input  logic [31:0] m_wb_dat_i,
    output logic        m_wb_we_o,
    output logic        m_wb_cyc_o,
    output logic        m_wb_stb_o,
    output logic [3:0]  m_wb_sel_o,
    output logic [2:0]  m_wb_cti_o,
    output logic [1:0]  m_wb_bte_o,
    input  logic        m_wb_ack_i,
    output logic        busy_o,
    output logic        timeout_o
);

    sd_arb_state_e state_q, state_d;
    sd_arb_owner_e owner_q, owner_d;
    sd_arb_owner_e last_q, last_d;
    logic [31:0]   adr_q, adr_d;
    logic [31:0]   dat_q, dat_d;
    logic          we_q, we_d;
    logic          rx_err_q, rx_err_d;
    logic          tx_err_q, tx_err_d;
    logic          timeout_q, timeout_d;

    logic rx_req;
    logic tx_req;
    logic grant_tx;
    logic own_cyc;
    logic busy;
    logic wd_tc;

    assign rx_req = rx_cyc_i & rx_stb_i;
    assign tx_req = tx_cyc_i & tx_stb_i;
    assign busy   = (state_q == SD_ARB_BUSY);

    // on a tie the requester that did not own the last transfer wins
    assign grant_tx = tx_req & (~rx_req | (last_q == SD_ARB_OWNER_RX));

    assign own_cyc = (owner_q == SD_ARB_OWNER_TX) ? tx_cyc_i : rx_cyc_i;

    sd_wb_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_wd (
        .clk  (clk),
        .rst  (rst),
        .clr_i(~busy),
        .en_i (busy & ~m_wb_ack_i),
        .tc_o (wd_tc)
    );

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        we_d      = we_q;
        rx_err_d  = 1'b0;
        tx_err_d  = 1'b0;
        timeout_d = timeout_q;
        unique case (state_q)
            SD_ARB_IDLE: begin
                if (rx_req || tx_req) begin
                    state_d = SD_ARB_BUSY;
                    if (grant_tx) begin
                        owner_d = SD_ARB_OWNER_TX;
                        adr_d   = tx_adr_i;
                        dat_d   = tx_dat_i;
                        we_d    = tx_we_i;
                    end else begin
                        owner_d = SD_ARB_OWNER_RX;
                        adr_d   = rx_adr_i;
                        dat_d   = rx_dat_i;
                        we_d    = rx_we_i;
                    end
                end
            end
            SD_ARB_BUSY: begin
                // ack outranks both a dropped cyc and the watchdog
                if (m_wb_ack_i) begin
                    state_d = SD_ARB_IDLE;
                    last_d  = owner_q;
                    we_d    = 1'b0;
                end else if (!own_cyc) begin
                    // requester gave up: release quietly, keep fairness state
                    state_d = SD_ARB_IDLE;
                    we_d    = 1'b0;
                end else if (wd_tc) begin
                    state_d   = SD_ARB_IDLE;
                    we_d      = 1'b0;
                    last_d    = owner_q;
                    timeout_d = 1'b1;
                    rx_err_d  = (owner_q == SD_ARB_OWNER_RX);
                    tx_err_d  = (owner_q == SD_ARB_OWNER_TX);
                end
            end
            default: begin
                state_d = SD_ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= SD_ARB_IDLE;
            owner_q   <= SD_ARB_OWNER_RX;
            last_q    <= SD_ARB_OWNER_TX;
            adr_q     <= '0;
            dat_q     <= '0;
            we_q      <= 1'b0;
            rx_err_q  <= 1'b0;
            tx_err_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            adr_q     <= adr_d;
            dat_q     <= dat_d;
            we_q      <= we_d;
            rx_err_q  <= rx_err_d;
            tx_err_q  <= tx_err_d;
            timeout_q <= timeout_d;
        end
    end

    assign rx_ack_o = m_wb_ack_i & busy & (owner_q == SD_ARB_OWNER_RX);
    assign tx_ack_o = m_wb_ack_i & busy & (owner_q == SD_ARB_OWNER_TX);
    assign tx_dat_o = m_wb_dat_i;

    assign rx_err_o   = rx_err_q;
    assign tx_err_o   = tx_err_q;
    assign timeout_o  = timeout_q;
    assign busy_o     = busy;
    assign m_wb_cyc_o = busy;
    assign m_wb_stb_o = busy;
    assign m_wb_we_o  = we_q;
    assign m_wb_adr_o = adr_q;
    assign m_wb_dat_o = dat_q;
    assign m_wb_sel_o = 4'hF;
    assign m_wb_cti_o = 3'b000;
    assign m_wb_bte_o = 2'b00;

endmodule

// File: tb/tb_sd_wb_master_arb.sv
// Scoreboard bench for sd_wb_master_arb with a short watchdog (TIMEOUT=4).
// Granted transfers are popped from an expected queue as the master starts.
module tb_sd_wb_master_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_cyc_i, rx_stb_i, rx_we_i;
    logic [31:0] rx_adr_i, rx_dat_i;
    logic        rx_ack_o, rx_err_o;
    logic        tx_cyc_i, tx_stb_i, tx_we_i;
    logic [31:0] tx_adr_i, tx_dat_i, tx_dat_o;
    logic        tx_ack_o, tx_err_o;
    logic [31:0] m_wb_adr_o, m_wb_dat_o, m_wb_dat_i;
    logic        m_wb_we_o, m_wb_cyc_o, m_wb_stb_o;
    logic [3:0]  m_wb_sel_o;
    logic [2:0]  m_wb_cti_o;
    logic [1:0]  m_wb_bte_o;
    logic        m_wb_ack_i;
    logic        busy_o, timeout_o;

    typedef struct packed {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
    } xfer_t;

    xfer_t exp_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    logic  cyc_prev = 1'b0;

    always #5 clk = ~clk;

    sd_wb_master_arb #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .rx_cyc_i(rx_cyc_i), .rx_stb_i(rx_stb_i), .rx_we_i(rx_we_i),
        .rx_adr_i(rx_adr_i), .rx_dat_i(rx_dat_i),
        .rx_ack_o(rx_ack_o), .rx_err_o(rx_err_o),
        .tx_cyc_i(tx_cyc_i), .tx_stb_i(tx_stb_i), .tx_we_i(tx_we_i),
        .tx_adr_i(tx_adr_i), .tx_dat_i(tx_dat_i), .tx_dat_o(tx_dat_o),
        .tx_ack_o(tx_ack_o), .tx_err_o(tx_err_o),
        .m_wb_adr_o(m_wb_adr_o), .m_wb_dat_o(m_wb_dat_o),
        .m_wb_dat_i(m_wb_dat_i), .m_wb_we_o(m_wb_we_o),
        .m_wb_cyc_o(m_wb_cyc_o), .m_wb_stb_o(m_wb_stb_o),
        .m_wb_sel_o(m_wb_sel_o), .m_wb_cti_o(m_wb_cti_o),
        .m_wb_bte_o(m_wb_bte_o), .m_wb_ack_i(m_wb_ack_i),
        .busy_o(busy_o), .timeout_o(timeout_o)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic we, input logic [31:0] adr,
                        input logic [31:0] dat);
        xfer_t x;
        x.we  = we;
        x.adr = adr;
        x.dat = dat;
        exp_q.push_back(x);
    endtask

    task automatic rx_req(input logic on, input logic [31:0] adr,
                          input logic [31:0] dat);
        rx_cyc_i = on;
        rx_stb_i = on;
        rx_we_i  = on;
        rx_adr_i = adr;
        rx_dat_i = dat;
    endtask

    task automatic tx_req(input logic on, input logic [31:0] adr);
        tx_cyc_i = on;
        tx_stb_i = on;
        tx_we_i  = 1'b0;
        tx_adr_i = adr;
        tx_dat_i = 32'h0;
    endtask

    // transfer-start monitor: compare latched master request to scoreboard
    always @(negedge clk) begin
        xfer_t e;
        if (m_wb_cyc_o && !cyc_prev) begin
            if (exp_q.size() == 0) begin
                check("sb_empty", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("sb_adr", m_wb_adr_o, e.adr);
                check("sb_dat", m_wb_dat_o, e.dat);
                check("sb_we", {31'd0, m_wb_we_o}, {31'd0, e.we});
            end
        end
        cyc_prev = m_wb_cyc_o;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got hang want finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int  cnt;
        logic seen;
        rst = 1'b1;
        rx_req(1'b0, 32'h0, 32'h0);
        tx_req(1'b0, 32'h0);
        m_wb_ack_i = 1'b0;
        m_wb_dat_i = 32'h0;
        repeat (2) @(negedge clk);
        check("rst_cyc", {31'd0, m_wb_cyc_o}, 32'd0);
        check("rst_stb", {31'd0, m_wb_stb_o}, 32'd0);
        check("rst_we", {31'd0, m_wb_we_o}, 32'd0);
        check("rst_adr", m_wb_adr_o, 32'd0);
        check("rst_dat", m_wb_dat_o, 32'd0);
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_to", {31'd0, timeout_o}, 32'd0);
        check("rst_errs", {30'd0, rx_err_o, tx_err_o}, 32'd0);
        check("sel", {28'd0, m_wb_sel_o}, 32'hF);
        check("cti_bte", {27'd0, m_wb_cti_o, m_wb_bte_o}, 32'd0);
        rst = 1'b0;

        // RX write, ack in third busy cycle
        rx_req(1'b1, 32'h1000, 32'hDEADBEEF);
        push(1'b1, 32'h1000, 32'hDEADBEEF);
        @(negedge clk);
        check("t1_cyc", {31'd0, m_wb_cyc_o}, 32'd1);
        check("t1_busy", {31'd0, busy_o}, 32'd1);
        repeat (2) @(negedge clk);
        m_wb_ack_i = 1'b1;
        #1;
        check("t1_rx_ack", {31'd0, rx_ack_o}, 32'd1);
        check("t1_tx_ack", {31'd0, tx_ack_o}, 32'd0);
        @(negedge clk);
        m_wb_ack_i = 1'b0;
        rx_req(1'b0, 32'h0, 32'h0);
        #1;
        check("t1_idle", {30'd0, m_wb_cyc_o, m_wb_we_o}, 32'd0);
        check("t1_ack_gone", {31'd0, rx_ack_o}, 32'd0);

        // tie from reset: RX, TX, RX alternation
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rx_req(1'b1, 32'h2000, 32'h11111111);
        tx_req(1'b1, 32'h3000);
        push(1'b1, 32'h2000, 32'h11111111);
        push(1'b0, 32'h3000, 32'h0);
        push(1'b1, 32'h2000, 32'h11111111);
        @(negedge clk);
        @(negedge clk);
        check("t2_hold_adr", m_wb_adr_o, 32'h2000);
        check("t2_hold_ack", {31'd0, tx_ack_o}, 32'd0);
        m_wb_ack_i = 1'b1;
        #1;
        check("t2_rx_ack", {31'd0, rx_ack_o}, 32'd1);
        @(negedge clk);
        m_wb_ack_i = 1'b0;
        check("t2_dead1", {31'd0, m_wb_cyc_o}, 32'd0);
        @(negedge clk);
        m_wb_dat_i = 32'hCAFEF00D;
        m_wb_ack_i = 1'b1;
        #1;
        check("t3_tx_ack", {31'd0, tx_ack_o}, 32'd1);
        check("t3_rx_ack", {31'd0, rx_ack_o}, 32'd0);
        check("t3_tx_dat", tx_dat_o, 32'hCAFEF00D);
        @(negedge clk);
        m_wb_ack_i = 1'b0;
        check("t2_dead2", {31'd0, m_wb_cyc_o}, 32'd0);
        @(negedge clk);
        m_wb_ack_i = 1'b1;
        #1;
        check("t2_rx_ack2", {31'd0, rx_ack_o}, 32'd1);
        @(negedge clk);
        m_wb_ack_i = 1'b0;
        rx_req(1'b0, 32'h0, 32'h0);
        tx_req(1'b0, 32'h0);

        // TX drops cyc mid-transfer: silent release
        tx_req(1'b1, 32'h4000);
        push(1'b0, 32'h4000, 32'h0);
        @(negedge clk);
        check("sa_cyc", {31'd0, m_wb_cyc_o}, 32'd1);
        tx_req(1'b0, 32'h0);
        @(negedge clk);
        check("sa_idle", {31'd0, m_wb_cyc_o}, 32'd0);
        check("sa_err", {31'd0, tx_err_o}, 32'd0);

        // reset while busy, request still pending
        rx_req(1'b1, 32'h5000, 32'h55555555);
        push(1'b1, 32'h5000, 32'h55555555);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rb_ctl", {29'd0, m_wb_cyc_o, m_wb_stb_o, m_wb_we_o}, 32'd0);
        check("rb_adr", m_wb_adr_o, 32'd0);
        check("rb_busy", {31'd0, busy_o}, 32'd0);
        push(1'b1, 32'h5000, 32'h55555555);
        rst = 1'b0;
        @(negedge clk);
        check("rb_regrant", {31'd0, m_wb_cyc_o}, 32'd1);

        // ack coincides with terminal count
        repeat (4) @(negedge clk);
        check("tc_still_busy", {31'd0, m_wb_stb_o}, 32'd1);
        m_wb_ack_i = 1'b1;
        #1;
        check("tc_ack", {31'd0, rx_ack_o}, 32'd1);
        @(negedge clk);
        m_wb_ack_i = 1'b0;
        rx_req(1'b0, 32'h0, 32'h0);
        check("tc_no_err", {31'd0, rx_err_o}, 32'd0);
        check("tc_no_to", {31'd0, timeout_o}, 32'd0);
        check("tc_idle", {31'd0, m_wb_cyc_o}, 32'd0);

        // watchdog abort of a hung RX write
        rx_req(1'b1, 32'h6000, 32'h66666666);
        push(1'b1, 32'h6000, 32'h66666666);
        cnt  = 0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (m_wb_stb_o) cnt++;
            if (rx_err_o) seen = 1'b1;
        end
        check("wd_err_seen", {31'd0, seen}, 32'd1);
        check("wd_stb_cycles", cnt, 32'd5);
        check("wd_to_set", {31'd0, timeout_o}, 32'd1);
        check("wd_idle", {31'd0, m_wb_cyc_o}, 32'd0);
        rx_req(1'b0, 32'h0, 32'h0);
        tx_req(1'b1, 32'h7000);
        push(1'b0, 32'h7000, 32'h0);
        @(negedge clk);
        check("wd_err_pulse", {31'd0, rx_err_o}, 32'd0);
        check("wd_tx_grant", {31'd0, m_wb_cyc_o}, 32'd1);
        check("wd_to_sticky", {31'd0, timeout_o}, 32'd1);
        m_wb_ack_i = 1'b1;
        #1;
        check("wd_tx_ack", {31'd0, tx_ack_o}, 32'd1);
        @(negedge clk);
        m_wb_ack_i = 1'b0;
        tx_req(1'b0, 32'h0);
        @(negedge clk);
        check("end_idle", {31'd0, m_wb_cyc_o}, 32'd0);
        check("sb_left", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
